// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scheduler and its bit encoder.
package ws2812_pkg;

  localparam int PIXEL_W = 24;

  // Default timing, in clk cycles.
  localparam int DEF_NUM_LEDS    = 3;
  localparam int DEF_T0H_CYCLES  = 5;
  localparam int DEF_T1H_CYCLES  = 10;
  localparam int DEF_BIT_CYCLES  = 15;
  localparam int DEF_LATCH_CYCLES = 29000;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Serialises one 24-bit GRB pixel, MSB first, into WS2812 high/low bit pulses.
// Handshake: a pixel is taken on any clk edge where valid && ready; ready is
// high when idle or during the very last cycle of the final bit, so the next
// pixel follows with no gap. done pulses one cycle before that last cycle so
// the scheduler has time to present the next pixel.
// dout is registered: it lags the internal bit counters by one cycle.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic               valid,
  output logic               ready,
  output logic               dout,
  output logic               done
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_DONE = CYC_W'(BIT_CYCLES - 2);
  localparam logic [CYC_W-1:0] HI1      = CYC_W'(T1H_CYCLES);
  localparam logic [CYC_W-1:0] HI0      = CYC_W'(T0H_CYCLES);
  localparam logic [4:0]       BIT_LAST = 5'(PIXEL_W - 1);

  logic               active;
  logic [PIXEL_W-1:0] shreg;
  logic [4:0]         bit_cnt;
  logic [CYC_W-1:0]   cyc;
  logic               last_bit;
  logic               hi_now;

  assign last_bit = (bit_cnt == BIT_LAST);
  assign ready    = !active || (last_bit && cyc == CYC_LAST);
  assign done     = active && last_bit && (cyc == CYC_DONE);
  assign hi_now   = active && (cyc < (shreg[PIXEL_W-1] ? HI1 : HI0));

  // Bit/cycle counters, shift register and the registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc     <= '0;
      dout    <= 1'b0;
    end else begin
      dout <= hi_now;
      if (valid && ready) begin
        active  <= 1'b1;
        shreg   <= pixel;
        bit_cnt <= '0;
        cyc     <= '0;
      end else if (active) begin
        if (cyc == CYC_LAST) begin
          cyc   <= '0;
          shreg <= {shreg[PIXEL_W-2:0], 1'b0};
          if (last_bit) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end else begin
          cyc <= cyc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Double-buffered WS2812 frame scheduler: host writes a back buffer, commit
// copies it to the front buffer, start transmits the front buffer followed by
// a latch gap. Owns the buffers, the frame FSM and the latch counter.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        commit,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        dout
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
  // LATCH is entered while the encoder still owes the last cycle of the final
  // bit plus its output register stage; the two extra counts make the low gap
  // after the last bit period exactly LATCH_CYCLES before frame_done.
  localparam int LATCH_LAST = LATCH_CYCLES + 2;
  localparam int LAT_W = $clog2(LATCH_LAST + 1);
  localparam logic [LAT_W-1:0] LAT_LAST_C = LAT_W'(LATCH_LAST);

  state_t state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [LAT_W-1:0]   latch_cnt;
  logic               pend_start;
  logic               pend_commit;
  logic [PIXEL_W-1:0] back_buf  [NUM_LEDS];
  logic [PIXEL_W-1:0] front_buf [NUM_LEDS];
  logic               enc_valid;
  logic               enc_ready;
  logic               enc_done;
  logic               latch_end;
  logic               do_copy;

  ws2812_bit_encoder #(
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .BIT_CYCLES(BIT_CYCLES)
  ) u_enc (
    .clk  (clk),
    .rst  (rst),
    .pixel(front_buf[idx]),
    .valid(enc_valid),
    .ready(enc_ready),
    .dout (dout),
    .done (enc_done)
  );

  // Next-state logic and FSM-derived outputs.
  always_comb begin
    state_next = state;
    enc_valid  = 1'b0;
    latch_end  = 1'b0;
    busy       = (state != IDLE);
    do_copy    = (commit && (state == IDLE || state == LATCH)) ||
                 (pend_commit && state == LATCH && latch_cnt == '0);
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD: begin
        enc_valid = 1'b1;
        if (enc_ready) state_next = SEND;
      end
      SEND:  if (enc_done) state_next = (idx == IDX_LAST) ? LATCH : LOAD;
      LATCH: if (latch_cnt == LAT_LAST_C) begin
        latch_end  = 1'b1;
        state_next = (pend_start || start) ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    frame_done = latch_end;
  end

  // State register, pixel index, latch counter and the one-deep pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      latch_cnt   <= '0;
      pend_start  <= 1'b0;
      pend_commit <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE || state == LATCH) begin
        idx <= '0;
      end else if (state == SEND && enc_done && idx != IDX_LAST) begin
        idx <= idx + 1'b1;
      end
      latch_cnt <= (state == LATCH && !latch_end) ? latch_cnt + 1'b1 : '0;
      if (state == IDLE || latch_end) begin
        pend_start <= 1'b0;
      end else if (start) begin
        pend_start <= 1'b1;
      end
      if (do_copy) begin
        pend_commit <= 1'b0;
      end else if (commit) begin
        pend_commit <= 1'b1;
      end
    end
  end

  // Pixel buffers; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        back_buf[i]  <= '0;
        front_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_en && wr_addr == 8'(i)) back_buf[i] <= wr_data;
        if (do_copy) begin
          front_buf[i] <= (wr_en && wr_addr == 8'(i)) ? wr_data : back_buf[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: a frame-position model predicts busy,
// frame_done and dout every cycle; directed scenarios add literal checks.
module tb_ws2812_frame_scheduler;

  localparam int N      = 3;
  localparam int T0H    = 5;
  localparam int T1H    = 10;
  localparam int BITC   = 15;
  localparam int LATCH  = 300;
  localparam int BITS_T = N * 24 * BITC;
  // Position of the frame_done cycle, counted from the start-sampling edge.
  localparam int T_FD   = 2 + BITS_T + LATCH;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [23:0] wr_data = 24'd0;
  logic        commit = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        dout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ws2812_frame_scheduler #(
    .NUM_LEDS(N), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .start(start),
    .busy(busy), .frame_done(frame_done), .dout(dout)
  );

  int total = 0;
  int bad = 0;
  int fd_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: frame position m_t, the snapshot being sent, buffers.
  logic [23:0] m_back  [N] = '{default: 24'd0};
  logic [23:0] m_front [N] = '{default: 24'd0};
  logic [23:0] m_frame [N] = '{default: 24'd0};
  logic        m_busy = 1'b0;
  logic        m_pend_start = 1'b0;
  logic        m_pend_commit = 1'b0;
  int          m_t = 0;

  function automatic logic m_dout(input int t);
    int u, p, b, ph;
    logic v;
    if (t < 2 || t >= 2 + BITS_T) return 1'b0;
    u  = t - 2;
    p  = u / (24 * BITC);
    b  = (u % (24 * BITC)) / BITC;
    ph = u % BITC;
    v  = m_frame[p][23-b];
    return (ph < (v ? T1H : T0H));
  endfunction

  always @(posedge clk) begin : model
    logic [23:0] nb [N];
    if (rst) begin
      m_back = '{default: 24'd0};
      m_front = '{default: 24'd0};
      m_busy = 1'b0;
      m_pend_start = 1'b0;
      m_pend_commit = 1'b0;
      m_t = 0;
    end else begin
      nb = m_back;
      if (wr_en && int'(wr_addr) < N) nb[int'(wr_addr)] = wr_data;
      if (commit) begin
        if (!m_busy || m_t >= 2 + BITS_T) m_front = nb;
        else m_pend_commit = 1'b1;
      end
      if (m_busy) begin
        if (m_t == T_FD) begin
          if (start || m_pend_start) begin
            m_t = 0;
            m_frame = m_front;
          end else begin
            m_busy = 1'b0;
          end
          m_pend_start = 1'b0;
        end else begin
          m_t++;
          if (start) m_pend_start = 1'b1;
          if (m_t == 2 + BITS_T && m_pend_commit) begin
            m_front = nb;
            m_pend_commit = 1'b0;
          end
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_t = 0;
        m_frame = m_front;
      end
      m_back = nb;
    end
  end

  // Scoreboard compare: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("busy_in_rst", 32'(busy), 32'd0);
      chk("dout_in_rst", 32'(dout), 32'd0);
      chk("fd_in_rst", 32'(frame_done), 32'd0);
    end else begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("dout", 32'(dout), 32'(m_busy ? m_dout(m_t) : 1'b0));
      chk("frame_done", 32'(frame_done), 32'(m_busy && m_t == T_FD));
    end
    if (frame_done === 1'b1) fd_count++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] d, input logic with_commit);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d; commit = with_commit;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_fd(output int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 5000);
    chk("wait_frame_done", 32'(frame_done), 32'd1);
    c = cyc;
  endtask

  task automatic wait_rise(output int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (dout !== 1'b1 && n < 5000);
    chk("wait_dout_rise", 32'(dout), 32'd1);
    c = cyc;
  endtask

  task automatic capture_frame(output logic [71:0] bits, output int rise_c, output int werr);
    wait_rise(rise_c);
    werr = 0;
    bits = '0;
    for (int b = 0; b < 72; b++) begin
      int hi = 0;
      int lo = 0;
      while (dout === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
      if (b == 71) begin
        while (dout === 1'b0 && lo < BITC - hi) begin lo++; @(negedge clk); end
      end else begin
        while (dout === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
      end
      bits[71-b] = (hi == T1H);
      if (!((hi == T1H && lo == BITC - T1H) || (hi == T0H && lo == BITC - T0H))) werr++;
    end
  endtask

  task automatic chk_pixels(input string tag, input logic [71:0] bits,
                            input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
    chk({tag, "_px0"}, 32'(bits[71:48]), 32'(p0));
    chk({tag, "_px1"}, 32'(bits[47:24]), 32'(p1));
    chk({tag, "_px2"}, 32'(bits[23:0]),  32'(p2));
  endtask

  initial begin : watchdog
    #3000000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int sc, rc, fc, rc2, fc2, werr, fd0, dummy;
    logic [71:0] bits;

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic frame; last write shares its edge with commit
    write_px(0, 24'h00FF00, 1'b0);
    write_px(1, 24'hFF0000, 1'b0);
    write_px(2, 24'h0000FF, 1'b1);
    tick(2);
    pulse_start(sc);
    chk("busy_after_start", 32'(busy), 32'd1);
    capture_frame(bits, rc, werr);
    chk("start_to_rise", 32'(rc - sc), 32'd2);
    chk_pixels("f1", bits, 24'h00FF00, 24'hFF0000, 24'h0000FF);
    chk("f1_bit_widths", 32'(werr), 32'd0);
    wait_fd(fc);
    chk("rise_to_frame_done", 32'(fc - rc), 32'(72 * 15 + LATCH));
    tick(3);
    chk("idle_after_frame", 32'(busy), 32'd0);

    // Commit during SEND: current frame unchanged, next frame updated
    pulse_start(sc);
    fork
      capture_frame(bits, rc, werr);
      begin
        tick(100);
        write_px(0, 24'hFFFFFF, 1'b1);
      end
    join
    chk_pixels("f2", bits, 24'h00FF00, 24'hFF0000, 24'h0000FF);
    wait_fd(fc);
    tick(2);
    pulse_start(sc);
    capture_frame(bits, rc, werr);
    chk_pixels("f3", bits, 24'hFFFFFF, 24'hFF0000, 24'h0000FF);
    chk("f3_bit_widths", 32'(werr), 32'd0);
    wait_fd(fc);
    tick(2);

    // Three starts while busy give exactly one back-to-back frame
    fd0 = fd_count;
    pulse_start(sc);
    tick(50);
    pulse_start(dummy);
    tick(100);
    pulse_start(dummy);
    tick(500);
    pulse_start(dummy);
    wait_fd(fc);
    wait_rise(rc2);
    chk("frame_done_to_restart_rise", 32'(rc2 - fc), 32'd3);
    wait_fd(fc2);
    chk("restart_rise_to_frame_done", 32'(fc2 - rc2), 32'(72 * 15 + LATCH));
    tick(200);
    chk("pending_frame_count", 32'(fd_count - fd0), 32'd2);
    chk("idle_after_pending", 32'(busy), 32'd0);

    // Out-of-range write leaves the front buffer unchanged
    write_px(5, 24'h123456, 1'b0);
    do_commit();
    tick(1);
    pulse_start(sc);
    capture_frame(bits, rc, werr);
    chk_pixels("f5", bits, 24'hFFFFFF, 24'hFF0000, 24'h0000FF);
    wait_fd(fc);
    tick(2);

    // Reset while pixel 1 bit 23 is high
    pulse_start(sc);
    tick(362);
    chk("pre_reset_dout", 32'(dout), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_dout", 32'(dout), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    pulse_start(sc);
    capture_frame(bits, rc, werr);
    chk_pixels("after_reset", bits, 24'h000000, 24'h000000, 24'h000000);
    chk("after_reset_widths", 32'(werr), 32'd0);
    wait_fd(fc);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
